// File: rtl/led_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared defaults and LED polarity for the pattern and fader stages.
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int DEF_WIDTH      = 5;
    localparam int DEF_PWM_BITS   = 4;
    localparam int DEF_DECAY_SIZE = 8;

    // Board LEDs are active-low on both the pattern input and the pin drive.
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_fade_chan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_fade_chan
// Purpose  : One LED channel: brightness level, duty mapping, registered drive.
//            LED_FADER_GAMMA_EN selects a squared (gamma) duty curve.
// Revision : 1.0 - initial release
// ============================================================================
module led_fade_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                led_q,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] cmp;

    // Reload has priority over a coincident decay tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level <= '0;
        end else if (led_q == LED_ON) begin
            level <= LEVEL_MAX;
        end else if (decay_tick && (level != '0)) begin
            level <= level - LEVEL_ONE;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;

    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
        cmp      = level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb begin
        cmp = level;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led <= LED_OFF;
        end else if (led_q == LED_ON) begin
            led <= LED_ON;
        end else begin
            led <= (pwm_cnt < cmp) ? LED_ON : LED_OFF;
        end
    end

endmodule : led_fade_chan
`default_nettype wire

// File: rtl/led_fader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_fader
// Purpose  : Active-low LED pattern fader: full-on while driven, PWM fade-out
//            after release. Optional macro LED_FADER_GAMMA_EN (gamma duty).
// Revision : 1.0 - initial release
// ============================================================================
module led_fader
    import led_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int DECAY_SIZE = DEF_DECAY_SIZE
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] led,
    output logic             decay_tick
);

    localparam logic [PWM_BITS-1:0]   PWM_ONE      = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [DECAY_SIZE-1:0] PRESCALE_ONE = {{(DECAY_SIZE-1){1'b0}}, 1'b1};
    localparam logic [DECAY_SIZE-1:0] PRESCALE_END = '1;

    logic [WIDTH-1:0]      led_q;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [DECAY_SIZE-1:0] prescaler;

    // led_in already lives in this clock domain; one register stage suffices.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q <= {WIDTH{LED_OFF}};
        end else begin
            led_q <= led_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt    <= '0;
            prescaler  <= '0;
            decay_tick <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + PWM_ONE;
            prescaler  <= prescaler + PRESCALE_ONE;
            decay_tick <= (prescaler == PRESCALE_END);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk        (clk),
            .rstn       (rstn),
            .led_q      (led_q[i]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_cnt),
            .led        (led[i])
        );
    end

endmodule : led_fader
`default_nettype wire

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter WIDTH, default 5, sets the number of LED channels and matches the pattern-stage width.
REQ-002 Parameter PWM_BITS, default 4, sets the brightness level width and the PWM period, which is 2**PWM_BITS cycles.
REQ-003 Parameter DECAY_SIZE, default 8, sets the decay prescaler width; one decay tick occurs every 2**DECAY_SIZE cycles.
REQ-004 Port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port led_in, input, WIDTH bits: active-low LED pattern from the upstream pattern stage; 0 means channel on.
REQ-007 Port led, output, WIDTH bits: active-low faded LED drive to the board pins.
REQ-008 Port decay_tick, output, 1 bit: registered one-cycle pulse marking each decay tick, for observation.

Function
REQ-009 led_in SHALL be registered once (led_q) before use; no other synchroniser, since led_in is in the clk domain.
REQ-010 pwm_cnt, PWM_BITS wide, SHALL free-run 0 to 2**PWM_BITS-1 and wrap to 0.
REQ-011 Decay prescaler, DECAY_SIZE wide, SHALL free-run and wrap; decay_tick SHALL be 1 in the cycle after the prescaler equals all-ones.
REQ-012 Per channel i, level[i] (PWM_BITS) SHALL load 2**PWM_BITS-1 whenever led_q[i]==0.
REQ-013 Otherwise level[i] SHALL decrement by 1 on each decay_tick, saturating at 0 with no wrap.
REQ-014 When reload and decay tick coincide, reload SHALL win.
REQ-015 cmp[i] SHALL equal level[i] (linear); see REQ-022 for the alternative.
REQ-016 While led_q[i]==0, led[i] SHALL be 0 (100% on), overriding the PWM.
REQ-017 Otherwise led[i] SHALL be the registered value ~(pwm_cnt < cmp[i]), giving duty cmp/2**PWM_BITS.
REQ-018 Latency from led_in[i] falling to led[i] falling SHALL be exactly 2 cycles; release starts the fade on the same 2-cycle path.

Reset
REQ-019 While rstn==0: led SHALL be all-ones (all off), decay_tick 0, level, pwm_cnt, prescaler and led_q[i] (reset to 1) cleared, asynchronously and without a clock edge.
REQ-020 Reset asserted mid-fade SHALL abort the fade; after release, channels stay off until led_in reasserts.
REQ-021 The first pwm_cnt and prescaler increment SHALL occur on the first rising edge after rstn deasserts.

Configuration
REQ-022 With macro LED_FADER_GAMMA_EN defined, cmp[i] SHALL be (level[i]*level[i]) >> PWM_BITS, using a 2*PWM_BITS-bit intermediate product; without it, cmp[i]=level[i].
REQ-023 The macro SHALL NOT change ports, latency or reset values.

Structure
REQ-024 Package led_pkg SHALL hold the default WIDTH, PWM_BITS and DECAY_SIZE constants and the LED active-low polarity constant shared with the pattern stage.
REQ-025 One sub-module, led_fade_chan, SHALL implement the per-channel level register, the cmp mapping and the output register. It is instantiated WIDTH times by generate, with pwm_cnt and decay_tick shared from the top.

Verification
REQ-026 Reset: rstn=0 with led_in=5'b00000 -> led=5'b11111 and decay_tick=0 immediately; rstn=1 -> led[4:0]=0 by the 2nd edge.
REQ-027 Hold: led_in[0]=0 for 5000 cycles -> led[0]=0 on every cycle from 2 cycles after assertion.
REQ-028 Linear fade: led_in[0] released after level=15 -> led[0] low 15 of 16 cycles until the first tick, 14 of 16 after it. It stays 1 within 16*256 cycles and remains 1 for a further 10000 cycles (no underflow).
REQ-029 Collision: drive led_q[2]=0 in the same cycle decay_tick=1 -> level[2]=15, not 14.
REQ-030 Gamma (LED_FADER_GAMMA_EN): level=8 -> cmp=4 -> led low exactly 4 of 16 cycles; level=15 -> cmp=14.
REQ-031 Mid-fade reset: rstn pulsed low for 1 cycle at level=7 -> led=5'b11111 asynchronously, all levels 0 after release.
